falafel_host_if: RTL and testbench
==================================

// Module: falafel_host_if
// PURPOSE
//  Host-facing front-end of the allocator; sits directly upstream of falafel_core.
//  Decodes single-beat host register accesses into alloc/free commands and pushes them into two command FIFOs.
//  Pops allocation results from a response FIFO back to the host.
//  Owns all three FIFOs and presents the core with first-word-fall-through read/write ports.
// PARAMETERS
//  DATA_W      32  width of host data, FIFO entries and core FIFO ports
//  ADDR_W      4   host register byte-address width
//  FIFO_DEPTH  8   entries per FIFO; power of two, 2..128
// PORTS
//  clk_i                input   1       clock
//  rst_ni               input   1       asynchronous active-low reset
//  host_req_val_i       input   1       host request valid
//  host_req_rdy_o       output  1       request accepted when val&rdy
//  host_req_is_write_i  input   1       1 = write, 0 = read
//  host_req_addr_i      input   ADDR_W  register byte address
//  host_req_data_i      input   DATA_W  write data
//  host_rsp_val_o       output  1       response valid
//  host_rsp_rdy_i       input   1       host takes response when val&rdy
//  host_rsp_data_o      output  DATA_W  read data (0 for writes and errors)
//  host_rsp_err_o       output  1       access error flag
//  alloc_fifo_empty_o   output  1       alloc FIFO empty
//  alloc_fifo_read_i    input   1       core pops alloc FIFO
//  alloc_fifo_dout_o    output  DATA_W  head entry: requested size
//  free_fifo_empty_o    output  1       free FIFO empty
//  free_fifo_read_i     input   1       core pops free FIFO
//  free_fifo_dout_o     output  DATA_W  head entry: pointer to free
//  resp_fifo_full_o     output  1       resp FIFO full
//  resp_fifo_write_i    input   1       core pushes result
//  resp_fifo_din_i      input   DATA_W  result pointer
// BEHAVIOUR
//  Register map (byte address)
//   0x0 ALLOC (W) : push data to alloc FIFO
//   0x4 FREE (W)  : push data to free FIFO
//   0x8 RESP (R)  : pop resp FIFO; returns popped entry
//   0xC STATUS (R): {resp_count[15:8], 5'b0, resp_empty[2], free_full[1], alloc_full[0]}, upper bits 0
//  FSM
//   IDLE -> RSP on accepted request
//   RSP -> IDLE on host_rsp_rdy_i
//   At most one outstanding request; host_req_rdy_o = 0 in RSP.
//  Timing
//   Side effect (push/pop) occurs in the acceptance cycle.
//   host_rsp_val_o rises the next cycle; response data is registered and held stable until taken.
//  Backpressure in IDLE
//   host_req_rdy_o = 0 for a valid ALLOC write while alloc FIFO is full.
//   Same rule for FREE write with free FIFO full, and for RESP read with resp FIFO empty.
//   Otherwise host_req_rdy_o = 1.
//   Host polls STATUS to avoid indefinite stalls.
//  Errors (err=1, data=0, no side effect, accepted immediately)
//   Read of ALLOC/FREE, write of RESP/STATUS, unmapped address, misaligned address (addr[1:0] != 0).
//  FIFO rules
//   FWFT: dout_o shows the head entry whenever empty_o = 0.
//   Read when empty is ignored; write when full is ignored.
//   Write is accepted when full even if a read happens in the same cycle.
//   Simultaneous read+write when neither empty nor full: count unchanged.
//   Pointers wrap modulo FIFO_DEPTH; count width is $clog2(FIFO_DEPTH+1).
//  Reset (async, any time)
//   All FIFOs emptied; FSM to IDLE; any pending response dropped.
//   Output values: host_req_rdy_o = 1, host_rsp_val_o = 0, host_rsp_data_o = 0, host_rsp_err_o = 0.
//   Output values: alloc/free empty = 1, resp_fifo_full_o = 0, douts = 0.
// STRUCTURE
//  Shared package falafel_pkg gets:
//   HOST_REG_ALLOC/FREE/RESP/STATUS address constants
//   host_status_t packed struct
//   host_if_state_e enum
//  Sub-module falafel_fifo (parametric DATA_W/DEPTH FWFT FIFO with count output) is instantiated three times.
//  The decode FSM stays in this file.
// TESTING
//  Reset release -> rdy = 1, rsp_val = 0, alloc/free empty = 1, STATUS read = 0x00000004.
//  Write ALLOC 0x20 -> next cycle rsp_val = 1, err = 0; alloc_empty = 0, alloc_dout = 0x20; core read -> empty.
//  Push 8 FREE writes (0x100..0x170), then a 9th -> rdy stays 0 until core read; FIFO order preserved across wrap.
//  Core writes 0x1008 into resp FIFO; host reads RESP -> data = 0x1008; RESP read when empty stalls until core write.
//  Read 0x0 / write 0xC / address 0x6 -> err = 1, data = 0, FIFO counts unchanged.
//  Core write+read same cycle at full/empty, and async reset asserted while in RSP -> rules above hold; rsp_val = 0.

Source files
------------

// File: rtl/falafel_pkg.sv
// Shared definitions for the falafel allocator host front-end: register map,
// STATUS word layout and host-interface FSM states.
package falafel_pkg;

    localparam logic [31:0] HOST_REG_ALLOC  = 32'h0;
    localparam logic [31:0] HOST_REG_FREE   = 32'h4;
    localparam logic [31:0] HOST_REG_RESP   = 32'h8;
    localparam logic [31:0] HOST_REG_STATUS = 32'hC;

    typedef struct packed {
        logic [15:0] rsvd_hi;
        logic [7:0]  resp_count;
        logic [4:0]  rsvd_lo;
        logic        resp_empty;
        logic        free_full;
        logic        alloc_full;
    } host_status_t;

    typedef enum logic {
        HOST_IDLE = 1'b0,
        HOST_RSP  = 1'b1
    } host_if_state_e;

endpackage

// File: rtl/falafel_fifo.sv
// First-word-fall-through FIFO with occupancy count; dout reads 0 while empty
// so nothing undefined ever leaves the block.
module falafel_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] din,
    input  logic              rd_en,
    output logic [DATA_W-1:0] dout,
    output logic              empty,
    output logic [CNT_W-1:0]  count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              full;
    logic              do_rd;
    logic              do_wr;

    assign empty = (count == '0);
    assign full  = (count == CNT_W'(DEPTH));
    assign do_rd = rd_en && !empty;
    // A pop in the same cycle frees the slot, so a write at full still lands.
    assign do_wr = wr_en && (!full || do_rd);
    assign dout  = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/falafel_host_if.sv
// Host register front-end of the allocator: decodes single-beat host accesses
// into alloc/free commands and returns allocation results from the core.
module falafel_host_if
    import falafel_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              host_req_val_i,
    output logic              host_req_rdy_o,
    input  logic              host_req_is_write_i,
    input  logic [ADDR_W-1:0] host_req_addr_i,
    input  logic [DATA_W-1:0] host_req_data_i,
    output logic              host_rsp_val_o,
    input  logic              host_rsp_rdy_i,
    output logic [DATA_W-1:0] host_rsp_data_o,
    output logic              host_rsp_err_o,
    output logic              alloc_fifo_empty_o,
    input  logic              alloc_fifo_read_i,
    output logic [DATA_W-1:0] alloc_fifo_dout_o,
    output logic              free_fifo_empty_o,
    input  logic              free_fifo_read_i,
    output logic [DATA_W-1:0] free_fifo_dout_o,
    output logic              resp_fifo_full_o,
    input  logic              resp_fifo_write_i,
    input  logic [DATA_W-1:0] resp_fifo_din_i
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    // Handshake: a request transfers on a cycle where host_req_val_i and
    // host_req_rdy_o are both high; a response transfers where host_rsp_val_o
    // and host_rsp_rdy_i are both high. Payloads are stable while valid waits.

    host_if_state_e    state;
    host_if_state_e    next_state;
    logic [31:0]       addr;
    logic              hit_alloc;
    logic              hit_free;
    logic              hit_resp;
    logic              hit_status;
    logic              hit_err;
    logic              stall;
    logic              accept;
    logic              req_rdy;
    logic [CNT_W-1:0]  alloc_count;
    logic [CNT_W-1:0]  free_count;
    logic [CNT_W-1:0]  resp_count;
    logic              alloc_full;
    logic              free_full;
    logic              resp_empty;
    logic [DATA_W-1:0] resp_dout;
    host_status_t      status;
    logic [DATA_W-1:0] rsp_data_nxt;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_err;

    assign alloc_full = (alloc_count == CNT_W'(FIFO_DEPTH));
    assign free_full  = (free_count == CNT_W'(FIFO_DEPTH));
    assign resp_fifo_full_o = (resp_count == CNT_W'(FIFO_DEPTH));

    // Misaligned addresses never equal a register constant, so they fall to error.
    always_comb begin
        addr       = 32'(host_req_addr_i);
        hit_alloc  = host_req_is_write_i  && (addr == HOST_REG_ALLOC);
        hit_free   = host_req_is_write_i  && (addr == HOST_REG_FREE);
        hit_resp   = !host_req_is_write_i && (addr == HOST_REG_RESP);
        hit_status = !host_req_is_write_i && (addr == HOST_REG_STATUS);
        hit_err    = !(hit_alloc || hit_free || hit_resp || hit_status);
        stall      = (hit_alloc && alloc_full) || (hit_free && free_full)
                   || (hit_resp && resp_empty);
    end

    always_comb begin
        status            = '0;
        status.resp_count = 8'(resp_count);
        status.resp_empty = resp_empty;
        status.free_full  = free_full;
        status.alloc_full = alloc_full;
        rsp_data_nxt      = '0;
        if (hit_resp) begin
            rsp_data_nxt = resp_dout;
        end else if (hit_status) begin
            rsp_data_nxt = DATA_W'(status);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= HOST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        req_rdy    = 1'b0;
        accept     = 1'b0;
        case (state)
            HOST_IDLE: begin
                req_rdy = !(host_req_val_i && stall);
                if (host_req_val_i && req_rdy) begin
                    accept     = 1'b1;
                    next_state = HOST_RSP;
                end
            end
            HOST_RSP: begin
                if (host_rsp_rdy_i) begin
                    next_state = HOST_IDLE;
                end
            end
            default: next_state = HOST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp_data <= '0;
            rsp_err  <= 1'b0;
        end else if (accept) begin
            rsp_data <= rsp_data_nxt;
            rsp_err  <= hit_err;
        end
    end

    assign host_req_rdy_o  = req_rdy;
    assign host_rsp_val_o  = (state == HOST_RSP);
    assign host_rsp_data_o = rsp_data;
    assign host_rsp_err_o  = rsp_err;

    falafel_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_alloc_fifo (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .wr_en (accept && hit_alloc),
        .din   (host_req_data_i),
        .rd_en (alloc_fifo_read_i),
        .dout  (alloc_fifo_dout_o),
        .empty (alloc_fifo_empty_o),
        .count (alloc_count)
    );

    falafel_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_free_fifo (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .wr_en (accept && hit_free),
        .din   (host_req_data_i),
        .rd_en (free_fifo_read_i),
        .dout  (free_fifo_dout_o),
        .empty (free_fifo_empty_o),
        .count (free_count)
    );

    falafel_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_resp_fifo (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .wr_en (resp_fifo_write_i),
        .din   (resp_fifo_din_i),
        .rd_en (accept && hit_resp),
        .dout  (resp_dout),
        .empty (resp_empty),
        .count (resp_count)
    );

endmodule

// File: tb/tb_falafel_host_if.sv
// Directed bench for falafel_host_if: a host driver, core-side drivers and
// queue-based models of the three FIFOs predicting every response and pop.
module tb_falafel_host_if;

    localparam int DW    = 32;
    localparam int AW    = 4;
    localparam int DEPTH = 8;

    logic          clk;
    logic          rst_n;
    logic          host_req_val;
    logic          host_req_rdy;
    logic          host_req_is_write;
    logic [AW-1:0] host_req_addr;
    logic [DW-1:0] host_req_data;
    logic          host_rsp_val;
    logic          host_rsp_rdy;
    logic [DW-1:0] host_rsp_data;
    logic          host_rsp_err;
    logic          alloc_empty;
    logic          alloc_read;
    logic [DW-1:0] alloc_dout;
    logic          free_empty;
    logic          free_read;
    logic [DW-1:0] free_dout;
    logic          resp_full;
    logic          resp_write;
    logic [DW-1:0] resp_din;

    logic [32:0]   exp_q[$];
    logic [31:0]   alloc_q[$];
    logic [31:0]   free_q[$];
    logic [31:0]   resp_q[$];
    int            n_cmp;
    int            n_fail;

    falafel_host_if #(.DATA_W(DW), .ADDR_W(AW), .FIFO_DEPTH(DEPTH)) dut (
        .clk_i               (clk),
        .rst_ni              (rst_n),
        .host_req_val_i      (host_req_val),
        .host_req_rdy_o      (host_req_rdy),
        .host_req_is_write_i (host_req_is_write),
        .host_req_addr_i     (host_req_addr),
        .host_req_data_i     (host_req_data),
        .host_rsp_val_o      (host_rsp_val),
        .host_rsp_rdy_i      (host_rsp_rdy),
        .host_rsp_data_o     (host_rsp_data),
        .host_rsp_err_o      (host_rsp_err),
        .alloc_fifo_empty_o  (alloc_empty),
        .alloc_fifo_read_i   (alloc_read),
        .alloc_fifo_dout_o   (alloc_dout),
        .free_fifo_empty_o   (free_empty),
        .free_fifo_read_i    (free_read),
        .free_fifo_dout_o    (free_dout),
        .resp_fifo_full_o    (resp_full),
        .resp_fifo_write_i   (resp_write),
        .resp_fifo_din_i     (resp_din)
    );

    // clock / watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Host access from a negedge; returns on a negedge after the response is taken.
    task automatic host_req(input logic wr, input logic [AW-1:0] addr, input logic [31:0] data,
                            input logic core_push = 1'b0, input logic [31:0] core_data = 32'h0);
        int          waited;
        logic [32:0] exp;
        logic [31:0] held;
        host_req_val      = 1'b1;
        host_req_is_write = wr;
        host_req_addr     = addr;
        host_req_data     = data;
        #1;
        waited = 0;
        while (!host_req_rdy && waited < 50) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (waited >= 50) begin
            check("req_accept_budget", 64'(waited), 64'(0));
            host_req_val = 1'b0;
            return;
        end
        if (wr && addr == 4'h0) begin
            exp = 33'h0;
            alloc_q.push_back(data);
        end else if (wr && addr == 4'h4) begin
            exp = 33'h0;
            free_q.push_back(data);
        end else if (!wr && addr == 4'h8) begin
            exp = {1'b0, resp_q.pop_front()};
        end else if (!wr && addr == 4'hC) begin
            exp = {1'b0, 16'h0, 8'(resp_q.size()), 5'b0, resp_q.size() == 0,
                   free_q.size() == DEPTH, alloc_q.size() == DEPTH};
        end else begin
            exp = {1'b1, 32'h0};
        end
        if (core_push) resp_q.push_back(core_data);
        exp_q.push_back(exp);
        @(negedge clk);
        host_req_val = 1'b0;
        if (core_push) resp_write = 1'b0;
        check("rsp_val_rise", 64'(host_rsp_val), 64'(1));
        held = host_rsp_data;
        @(negedge clk);
        check("rsp_held_val", 64'(host_rsp_val), 64'(1));
        check("rsp_held_data", 64'(host_rsp_data), 64'(held));
        host_rsp_rdy = 1'b1;
        exp = exp_q.pop_front();
        check("rsp_err_data", 64'({host_rsp_err, host_rsp_data}), 64'(exp));
        @(negedge clk);
        host_rsp_rdy = 1'b0;
        check("rsp_val_fall", 64'(host_rsp_val), 64'(0));
    endtask

    task automatic core_pop_alloc();
        check("alloc_nonempty", 64'(alloc_empty), 64'(0));
        if (alloc_q.size() > 0) check("alloc_dout", 64'(alloc_dout), 64'(alloc_q.pop_front()));
        alloc_read = 1'b1;
        @(negedge clk);
        alloc_read = 1'b0;
    endtask

    task automatic core_pop_free();
        check("free_nonempty", 64'(free_empty), 64'(0));
        if (free_q.size() > 0) check("free_dout", 64'(free_dout), 64'(free_q.pop_front()));
        free_read = 1'b1;
        @(negedge clk);
        free_read = 1'b0;
    endtask

    task automatic core_push_resp(input logic [31:0] data);
        resp_write = 1'b1;
        resp_din   = data;
        if (resp_q.size() < DEPTH) resp_q.push_back(data);
        @(negedge clk);
        resp_write = 1'b0;
    endtask

    task automatic hold_stalled(input string tag, input logic wr, input logic [AW-1:0] addr,
                                input logic [31:0] data);
        host_req_val      = 1'b1;
        host_req_is_write = wr;
        host_req_addr     = addr;
        host_req_data     = data;
        for (int i = 0; i < 3; i++) begin
            #1;
            check(tag, 64'(host_req_rdy), 64'(0));
            @(negedge clk);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        rst_n = 1'b0;
        host_req_val = 1'b0;
        host_req_is_write = 1'b0;
        host_req_addr = '0;
        host_req_data = '0;
        host_rsp_rdy = 1'b0;
        alloc_read = 1'b0;
        free_read = 1'b0;
        resp_write = 1'b0;
        resp_din = '0;
        repeat (2) @(negedge clk);

        check("rst_req_rdy", 64'(host_req_rdy), 64'(1));
        check("rst_rsp_val", 64'(host_rsp_val), 64'(0));
        check("rst_rsp_data", 64'({host_rsp_err, host_rsp_data}), 64'(0));
        check("rst_alloc_empty", 64'(alloc_empty), 64'(1));
        check("rst_free_empty", 64'(free_empty), 64'(1));
        check("rst_resp_full", 64'(resp_full), 64'(0));
        check("rst_douts", 64'({alloc_dout, free_dout}), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);

        host_req(1'b0, 4'hC, 32'h0);
        check("status_reset_word", 64'(32'h4), 64'(32'h4 & {28'h0, 4'(resp_q.size() == 0) << 2}));

        host_req(1'b1, 4'h0, 32'h20);
        check("alloc_dout_fwft", 64'(alloc_dout), 64'(32'h20));
        core_pop_alloc();
        check("alloc_empty_after_pop", 64'(alloc_empty), 64'(1));

        host_req(1'b1, 4'h4, 32'hFF);
        core_pop_free();
        for (int i = 0; i < DEPTH; i++) host_req(1'b1, 4'h4, 32'h100 + 32'(i) * 32'h10);
        host_req(1'b0, 4'hC, 32'h0);
        hold_stalled("free_full_stall", 1'b1, 4'h4, 32'h180);
        core_pop_free();
        host_req(1'b1, 4'h4, 32'h180);
        for (int i = 0; i < DEPTH; i++) core_pop_free();
        check("free_empty_drained", 64'(free_empty), 64'(1));

        core_push_resp(32'h1008);
        host_req(1'b0, 4'h8, 32'h0);
        hold_stalled("resp_empty_stall", 1'b0, 4'h8, 32'h0);
        core_push_resp(32'h2000);
        host_req(1'b0, 4'h8, 32'h0);

        core_push_resp(32'h3000);
        host_req(1'b0, 4'h0, 32'h0);
        host_req(1'b1, 4'hC, 32'h55);
        host_req(1'b1, 4'h6, 32'h77);
        host_req(1'b0, 4'h6, 32'h0);
        host_req(1'b1, 4'h8, 32'h99);
        host_req(1'b0, 4'h4, 32'h0);
        host_req(1'b0, 4'hC, 32'h0);
        check("err_alloc_untouched", 64'(alloc_empty), 64'(1));

        for (int i = 0; i < DEPTH - 1; i++) core_push_resp(32'h3100 + 32'(i));
        check("resp_full_flag", 64'(resp_full), 64'(1));
        resp_write = 1'b1;
        resp_din = 32'h4000;
        host_req(1'b0, 4'h8, 32'h0, 1'b1, 32'h4000);
        check("resp_full_after_rw", 64'(resp_full), 64'(1));
        core_push_resp(32'h5000);
        host_req(1'b0, 4'hC, 32'h0);
        for (int i = 0; i < DEPTH; i++) host_req(1'b0, 4'h8, 32'h0);
        host_req(1'b0, 4'hC, 32'h0);

        alloc_read = 1'b1;
        @(negedge clk);
        alloc_read = 1'b0;
        check("alloc_underflow_ignored", 64'(alloc_empty), 64'(1));
        host_req(1'b1, 4'h0, 32'h44);
        core_pop_alloc();
        check("alloc_empty_again", 64'(alloc_empty), 64'(1));

        host_req(1'b1, 4'h0, 32'h99);
        host_req(1'b1, 4'h0, 32'h9A);
        host_req_val = 1'b1;
        host_req_is_write = 1'b1;
        host_req_addr = 4'h0;
        host_req_data = 32'h9B;
        @(negedge clk);
        host_req_val = 1'b0;
        check("rsp_val_before_reset", 64'(host_rsp_val), 64'(1));
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_rsp_val", 64'(host_rsp_val), 64'(0));
        check("arst_req_rdy", 64'(host_req_rdy), 64'(1));
        check("arst_rsp_data", 64'({host_rsp_err, host_rsp_data}), 64'(0));
        check("arst_alloc_empty", 64'(alloc_empty), 64'(1));
        check("arst_alloc_dout", 64'(alloc_dout), 64'(0));
        check("arst_resp_full", 64'(resp_full), 64'(0));
        alloc_q.delete();
        free_q.delete();
        resp_q.delete();
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        host_req(1'b0, 4'hC, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
